n2_wb_arbiter: RTL and testbench

//  Writeback stage directly downstream of the execute unit. Merges ALU results (from exec) and

---
 rtl/n2_wb_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_n2_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/n2_wb_arbiter.sv
// Writeback arbiter: merges LSU load results and exec ALU results onto one RF write port,
// parking displaced ALU results in an in-order FIFO. Optional perf counters: N2_WB_PERF_EN.

module n2_wb_arbiter_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             resetn,
    input logic             push_req,
    input logic             full,
    input logic [CNT_W-1:0] count
);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!resetn) !(push_req && full))
        else $error("exec result pushed into a full writeback FIFO");

    a_count_bound: assert property (@(posedge clk) disable iff (!resetn) count <= CNT_W'(DEPTH))
        else $error("writeback FIFO count out of range");
endmodule

module n2_wb_arbiter #(
    parameter int DEPTH    = 4,
    parameter int REG_BITS = 5
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   ex_we_i,
    input  logic [REG_BITS-1:0]    ex_dst_i,
    input  logic [31:0]            ex_data_i,
    input  logic [7:0]             ex_uid_i,
    input  logic                   lsu_we_i,
    input  logic [REG_BITS-1:0]    lsu_dst_i,
    input  logic [31:0]            lsu_data_i,
    input  logic [7:0]             lsu_uid_i,
    output logic                   ex_stall_o,
    output logic                   rf_we_o,
    output logic [REG_BITS-1:0]    rf_waddr_o,
    output logic [31:0]            rf_wdata_o,
    output logic [7:0]             rf_wuid_o,
    output logic [2**REG_BITS-1:0] pend_mask_o
`ifdef N2_WB_PERF_EN
    ,
    output logic [31:0]            perf_lsu_conflict_o,
    output logic [31:0]            perf_stall_o
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 2**REG_BITS;

    function automatic logic [NREG-1:0] onehot_dst(input logic [REG_BITS-1:0] d);
        onehot_dst = {{(NREG-1){1'b0}}, 1'b1} << d;
    endfunction

    logic [REG_BITS-1:0] dst_r  [DEPTH];
    logic [31:0]         data_r [DEPTH];
    logic [7:0]          uid_r  [DEPTH];
    logic [DEPTH-1:0]    vld_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                rf_we_r;
    logic [REG_BITS-1:0] rf_waddr_r;
    logic [31:0]         rf_wdata_r;
    logic [7:0]          rf_wuid_r;
    logic [NREG-1:0]     pend_mask_r;

    logic                lsu_v_s;
    logic                ex_v_s;
    logic                empty_s;
    logic                full_s;
    logic                head_vld_s;
    logic                sel_we_s;
    logic [REG_BITS-1:0] sel_dst_s;
    logic [31:0]         sel_data_s;
    logic [7:0]          sel_uid_s;
    logic                pop_s;
    logic                bypass_s;
    logic                push_req_s;
    logic                push_s;
    logic [DEPTH-1:0]    vld_n_s;
    logic [NREG-1:0]     mask_n_s;
    logic [CNT_W-1:0]    count_n_s;

    // Writes to x0 are dropped at the input so they never occupy the port or the FIFO.
    assign lsu_v_s    = lsu_we_i && (lsu_dst_i != {REG_BITS{1'b0}});
    assign ex_v_s     = ex_we_i && (ex_dst_i != {REG_BITS{1'b0}});
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign head_vld_s = !empty_s && vld_r[rd_ptr_r];
    assign push_req_s = ex_v_s && !bypass_s;
    assign push_s     = push_req_s && !full_s;
    assign count_n_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

    // Stall leaves room for the one result already in flight from exec.
    assign ex_stall_o  = (count_r >= CNT_W'(DEPTH-1));
    assign rf_we_o     = rf_we_r;
    assign rf_waddr_o  = rf_waddr_r;
    assign rf_wdata_o  = rf_wdata_r;
    assign rf_wuid_o   = rf_wuid_r;
    assign pend_mask_o = pend_mask_r;

    // Port selection: LSU, then FIFO head, then exec bypass, then silent pop of a killed head.
    always_comb begin
        sel_we_s   = 1'b0;
        sel_dst_s  = {REG_BITS{1'b0}};
        sel_data_s = 32'h0000_0000;
        sel_uid_s  = 8'h00;
        pop_s      = 1'b0;
        bypass_s   = 1'b0;
        if (lsu_v_s) begin
            sel_we_s   = 1'b1;
            sel_dst_s  = lsu_dst_i;
            sel_data_s = lsu_data_i;
            sel_uid_s  = lsu_uid_i;
        end else if (head_vld_s) begin
            sel_we_s   = 1'b1;
            sel_dst_s  = dst_r[rd_ptr_r];
            sel_data_s = data_r[rd_ptr_r];
            sel_uid_s  = uid_r[rd_ptr_r];
            pop_s      = 1'b1;
        end else if (empty_s && ex_v_s) begin
            sel_we_s   = 1'b1;
            sel_dst_s  = ex_dst_i;
            sel_data_s = ex_data_i;
            sel_uid_s  = ex_uid_i;
            bypass_s   = 1'b1;
        end else if (!empty_s) begin
            pop_s      = 1'b1;
        end else begin
            pop_s      = 1'b0;
        end
    end

    // Next valid bits: WAW kill first, then pop, then the younger tail push stays valid.
    always_comb begin
        vld_n_s  = vld_r;
        mask_n_s = {NREG{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (lsu_v_s && (dst_r[i] == lsu_dst_i)) begin
                vld_n_s[i] = 1'b0;
            end else begin
                vld_n_s[i] = vld_n_s[i];
            end
            if (pop_s && (rd_ptr_r == PTR_W'(i))) begin
                vld_n_s[i] = 1'b0;
            end else begin
                vld_n_s[i] = vld_n_s[i];
            end
            if (push_s && (wr_ptr_r == PTR_W'(i))) begin
                vld_n_s[i] = 1'b1;
                mask_n_s   = mask_n_s | onehot_dst(ex_dst_i);
            end else if (vld_n_s[i]) begin
                mask_n_s   = mask_n_s | onehot_dst(dst_r[i]);
            end else begin
                mask_n_s   = mask_n_s;
            end
        end
    end

    // FIFO pointers, count, valid bits and pending mask.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            vld_r       <= {DEPTH{1'b0}};
            pend_mask_r <= {NREG{1'b0}};
        end else begin
            rd_ptr_r    <= pop_s  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            wr_ptr_r    <= push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            count_r     <= count_n_s;
            vld_r       <= vld_n_s;
            pend_mask_r <= mask_n_s;
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_r[i]  <= {REG_BITS{1'b0}};
                data_r[i] <= 32'h0000_0000;
                uid_r[i]  <= 8'h00;
            end
        end else if (push_s) begin
            dst_r[wr_ptr_r]  <= ex_dst_i;
            data_r[wr_ptr_r] <= ex_data_i;
            uid_r[wr_ptr_r]  <= ex_uid_i;
        end
    end

    // Registered RF write port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {REG_BITS{1'b0}};
            rf_wdata_r <= 32'h0000_0000;
            rf_wuid_r  <= 8'h00;
        end else begin
            rf_we_r    <= sel_we_s;
            rf_waddr_r <= sel_dst_s;
            rf_wdata_r <= sel_data_s;
            rf_wuid_r  <= sel_uid_s;
        end
    end

`ifdef N2_WB_PERF_EN
    logic [31:0] perf_conf_r;
    logic [31:0] perf_stall_r;

    assign perf_lsu_conflict_o = perf_conf_r;
    assign perf_stall_o        = perf_stall_r;

    // Saturating event counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_conf_r  <= 32'h0000_0000;
            perf_stall_r <= 32'h0000_0000;
        end else begin
            if (lsu_v_s && ex_v_s && (perf_conf_r != 32'hFFFF_FFFF)) begin
                perf_conf_r <= perf_conf_r + 32'h0000_0001;
            end
            if (ex_stall_o && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'h0000_0001;
            end
        end
    end
`endif

    n2_wb_arbiter_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk      (clk),
        .resetn   (resetn),
        .push_req (push_req_s),
        .full     (full_s),
        .count    (count_r)
    );
endmodule

// File: tb/tb_n2_wb_arbiter.sv
// Bench for n2_wb_arbiter: directed scenarios plus random traffic against a queue-based model.

module tb_n2_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int RB    = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ex_we, lsu_we;
    logic [RB-1:0] ex_dst, lsu_dst;
    logic [31:0]   ex_data, lsu_data;
    logic [7:0]    ex_uid, lsu_uid;
    logic          ex_stall_o, rf_we_o;
    logic [RB-1:0] rf_waddr_o;
    logic [31:0]   rf_wdata_o;
    logic [7:0]    rf_wuid_o;
    logic [31:0]   pend_mask_o;

    always #5 clk = ~clk;

    n2_wb_arbiter #(.DEPTH(DEPTH), .REG_BITS(RB)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ex_we_i     (ex_we),
        .ex_dst_i    (ex_dst),
        .ex_data_i   (ex_data),
        .ex_uid_i    (ex_uid),
        .lsu_we_i    (lsu_we),
        .lsu_dst_i   (lsu_dst),
        .lsu_data_i  (lsu_data),
        .lsu_uid_i   (lsu_uid),
        .ex_stall_o  (ex_stall_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_wuid_o   (rf_wuid_o),
        .pend_mask_o (pend_mask_o)
    );

    typedef struct {
        logic [RB-1:0] dst;
        logic [31:0]   data;
        logic [7:0]    uid;
        logic          vld;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'h0;
        foreach (q[i]) if (q[i].vld) m[q[i].dst] = 1'b1;
        return m;
    endfunction

    // One cycle: apply inputs, predict from the queue model, check after the edge.
    task automatic step(input logic lw, input logic [RB-1:0] ld, input logic [31:0] ldat,
                        input logic [7:0] lu, input logic ew, input logic [RB-1:0] ed,
                        input logic [31:0] edat, input logic [7:0] eu);
        logic lv, ev, bypassed, ewe;
        logic [RB-1:0] edst;
        logic [31:0] exd;
        logic [7:0] euid;
        int pre_size;
        ent_t h;
        lsu_we = lw; lsu_dst = ld; lsu_data = ldat; lsu_uid = lu;
        ex_we = ew;  ex_dst = ed;  ex_data = edat;  ex_uid = eu;
        check_eq("stall", 64'(ex_stall_o), 64'(q.size() >= DEPTH - 1));
        lv = lw && (ld != 5'd0);
        ev = ew && (ed != 5'd0);
        pre_size = q.size();
        bypassed = 1'b0; ewe = 1'b0; edst = 5'd0; exd = 32'h0; euid = 8'h0;
        if (lv) begin
            ewe = 1'b1; edst = ld; exd = ldat; euid = lu;
            foreach (q[i]) if (q[i].dst == ld) q[i].vld = 1'b0;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            if (h.vld) begin
                ewe = 1'b1; edst = h.dst; exd = h.data; euid = h.uid;
            end
        end else if (ev) begin
            ewe = 1'b1; edst = ed; exd = edat; euid = eu; bypassed = 1'b1;
        end
        if (ev && !bypassed && pre_size < DEPTH)
            q.push_back('{dst: ed, data: edat, uid: eu, vld: 1'b1});
        @(posedge clk); #1;
        check_eq("rf_we", 64'(rf_we_o), 64'(ewe));
        if (ewe) begin
            check_eq("rf_waddr", 64'(rf_waddr_o), 64'(edst));
            check_eq("rf_wdata", 64'(rf_wdata_o), 64'(exd));
            check_eq("rf_wuid", 64'(rf_wuid_o), 64'(euid));
        end
        check_eq("pend_mask", 64'(pend_mask_o), 64'(model_mask()));
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'h0, 8'h0, 1'b0, 5'd0, 32'h0, 8'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_we"}, 64'(rf_we_o), 64'h0);
        check_eq({tag, "_waddr"}, 64'(rf_waddr_o), 64'h0);
        check_eq({tag, "_wdata"}, 64'(rf_wdata_o), 64'h0);
        check_eq({tag, "_wuid"}, 64'(rf_wuid_o), 64'h0);
        check_eq({tag, "_pend"}, 64'(pend_mask_o), 64'h0);
        check_eq({tag, "_stall"}, 64'(ex_stall_o), 64'h0);
    endtask

    initial begin
        resetn = 1'b0;
        ex_we = 1'b0; ex_dst = 5'd0; ex_data = 32'h0; ex_uid = 8'h0;
        lsu_we = 1'b0; lsu_dst = 5'd0; lsu_data = 32'h0; lsu_uid = 8'h0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // Exec-only bypass
        step(1'b0, 5'd0, 32'h0, 8'h0, 1'b1, 5'd3, 32'h11, 8'h01);
        check_eq("s1_waddr", 64'(rf_waddr_o), 64'd3);
        check_eq("s1_wdata", 64'(rf_wdata_o), 64'h11);
        idle();

        // LSU/exec conflict
        step(1'b1, 5'd5, 32'hAA, 8'h02, 1'b1, 5'd6, 32'hBB, 8'h03);
        check_eq("s2_lsu_first", 64'(rf_waddr_o), 64'd5);
        check_eq("s2_pend6_set", 64'(pend_mask_o[6]), 64'd1);
        idle();
        check_eq("s2_alu_second", 64'(rf_wdata_o), 64'hBB);
        check_eq("s2_pend6_clr", 64'(pend_mask_o[6]), 64'd0);

        // WAW kill
        step(1'b1, 5'd9, 32'h99, 8'h04, 1'b1, 5'd7, 32'h77, 8'h05);
        step(1'b1, 5'd7, 32'h55, 8'h06, 1'b0, 5'd0, 32'h0, 8'h0);
        check_eq("s3_load_r7", 64'(rf_wdata_o), 64'h55);
        idle();
        check_eq("s3_killed_pop", 64'(rf_we_o), 64'd0);
        idle();

        // Back-pressure and in-order drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'(10 + i), 32'(32'h100 + i), 8'(8'h10 + i),
                 1'b1, 5'(20 + i), 32'(32'h200 + i), 8'(8'h20 + i));
        check_eq("s4_stall_full", 64'(ex_stall_o), 64'd1);
        for (int i = 0; i < 4; i++) idle();
        check_eq("s4_stall_drop", 64'(ex_stall_o), 64'd0);
        idle();

        // x0 writes dropped
        step(1'b0, 5'd0, 32'h0, 8'h0, 1'b1, 5'd0, 32'hDEAD, 8'h30);
        check_eq("s5_x0_nowrite", 64'(rf_we_o), 64'd0);
        step(1'b1, 5'd0, 32'hBEEF, 8'h31, 1'b0, 5'd0, 32'h0, 8'h0);

        // Async reset mid-drain
        step(1'b1, 5'd1, 32'h1, 8'h40, 1'b1, 5'd2, 32'h2, 8'h41);
        step(1'b1, 5'd3, 32'h3, 8'h42, 1'b1, 5'd4, 32'h4, 8'h43);
        idle();
        resetn = 1'b0;
        #1;
        check_zero_outputs("midreset");
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        idle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic lw, ew;
            lw = ($urandom_range(0, 99) < 40);
            ew = ($urandom_range(0, 99) < 65) && (q.size() < DEPTH);
            step(lw, 5'($urandom_range(0, 7)), $urandom, 8'($urandom),
                 ew, 5'($urandom_range(0, 7)), $urandom, 8'($urandom));
        end
        for (int i = 0; i < 6; i++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
